// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - phase codes and sequence helpers for the traffic light monitor
package tl_pkg;

    typedef enum logic [2:0] {
        PH_OFF = 3'd0,
        PH_HGS = 3'd1,
        PH_HGL = 3'd2,
        PH_HGR = 3'd3,
        PH_HY  = 3'd4,
        PH_FG  = 3'd5,
        PH_FY  = 3'd6,
        PH_BAD = 3'd7
    } phase_t;

    typedef enum logic {
        ST_UNSYNC = 1'b0,
        ST_SYNCED = 1'b1
    } mon_state_t;

    // Legal successor in the light cycle; OFF/BAD have none
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_HGS:  next_phase = PH_HGL;
            PH_HGL:  next_phase = PH_HGR;
            PH_HGR:  next_phase = PH_HY;
            PH_HY:   next_phase = PH_FG;
            PH_FG:   next_phase = PH_FY;
            PH_FY:   next_phase = PH_HGS;
            default: next_phase = PH_OFF;
        endcase
    endfunction

    // Yellow phases use the yellow minimum, everything else the green one
    function automatic logic [31:0] min_dwell(input phase_t p,
                                              input logic [31:0] min_green,
                                              input logic [31:0] min_yellow);
        case (p)
            PH_HY, PH_FY: min_dwell = min_yellow;
            default:      min_dwell = min_green;
        endcase
    endfunction

endpackage

// File: rtl/tl_lamp_decode.sv
// rtl/tl_lamp_decode.sv - combinational decode of eight lamp lines into a phase code
module tl_lamp_decode
    import tl_pkg::*;
(
    input  logic       i_hgs,
    input  logic       i_hgl,
    input  logic       i_hgr,
    input  logic       i_hy,
    input  logic       i_hr,
    input  logic       i_fg,
    input  logic       i_fy,
    input  logic       i_fr,
    output logic [2:0] o_phase
);

    logic [7:0] w_lamps;

    assign w_lamps = {i_hgs, i_hgl, i_hgr, i_hy, i_hr, i_fg, i_fy, i_fr};

    // Only the exact legal lamp patterns map to a phase; anything else is BAD
    always_comb begin
        o_phase = PH_BAD;
        case (w_lamps)
            8'b0000_0000: o_phase = PH_OFF;
            8'b1000_0001: o_phase = PH_HGS;
            8'b0100_0001: o_phase = PH_HGL;
            8'b0010_0001: o_phase = PH_HGR;
            8'b0001_0001: o_phase = PH_HY;
            8'b0000_1100: o_phase = PH_FG;
            8'b0000_1010: o_phase = PH_FY;
            default:      o_phase = PH_BAD;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive phase-sequence and dwell checker for traffic_light
module traffic_light_monitor
    import tl_pkg::*;
#(
    parameter int unsigned MIN_GREEN  = 2,
    parameter int unsigned MIN_YELLOW = 2,
    parameter int unsigned MAX_PHASE  = 64,
    parameter int unsigned DW         = $clog2(MAX_PHASE + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          HGS,
    input  logic          HGL,
    input  logic          HGR,
    input  logic          HY,
    input  logic          HR,
    input  logic          FG,
    input  logic          FY,
    input  logic          FR,
    input  logic          err_clr,
    output logic [2:0]    phase,
    output logic          synced,
    output logic          err_pattern,
    output logic          err_seq,
    output logic          err_dwell,
    output logic          err_sticky,
    output logic [7:0]    cycle_cnt,
    output logic [DW-1:0] dwell
);

    localparam logic [DW-1:0] L_DWELL_ONE = DW'(1);
    localparam logic [DW-1:0] L_DWELL_MAX = DW'(MAX_PHASE);

    logic [2:0]    w_code_raw;
    phase_t        w_code;

    mon_state_t    r_state;
    phase_t        r_phase;
    logic [DW-1:0] r_dwell;
    logic          r_first;
    logic [7:0]    r_cycle_cnt;
    logic          r_err_pattern;
    logic          r_err_seq;
    logic          r_err_dwell;
    logic          r_err_sticky;

    mon_state_t    w_state_nxt;
    phase_t        w_phase_nxt;
    logic [DW-1:0] w_dwell_nxt;
    logic          w_first_nxt;
    logic [7:0]    w_cycle_cnt_nxt;
    logic          w_err_pattern;
    logic          w_err_seq;
    logic          w_err_dwell;
    logic          w_err_sticky_nxt;

    tl_lamp_decode u_decode (
        .i_hgs   (HGS),
        .i_hgl   (HGL),
        .i_hgr   (HGR),
        .i_hy    (HY),
        .i_hr    (HR),
        .i_fg    (FG),
        .i_fy    (FY),
        .i_fr    (FR),
        .o_phase (w_code_raw)
    );

    assign w_code = phase_t'(w_code_raw);

    // Sync tracking, dwell/cycle bookkeeping and error classification for this sample
    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_dwell_nxt     = r_dwell;
        w_first_nxt     = r_first;
        w_cycle_cnt_nxt = r_cycle_cnt;
        w_err_pattern   = 1'b0;
        w_err_seq       = 1'b0;
        w_err_dwell     = 1'b0;
        case (r_state)
            ST_UNSYNC: begin
                if (w_code == PH_BAD) begin
                    w_err_pattern = 1'b1;
                end else if (w_code != PH_OFF) begin
                    // First phase after lock may be partial, so it is exempt from the minimum
                    w_state_nxt = ST_SYNCED;
                    w_phase_nxt = w_code;
                    w_dwell_nxt = L_DWELL_ONE;
                    w_first_nxt = 1'b1;
                end
            end
            ST_SYNCED: begin
                if (w_code == PH_OFF || w_code == PH_BAD) begin
                    w_err_pattern = 1'b1;
                    w_state_nxt   = ST_UNSYNC;
                    w_phase_nxt   = PH_OFF;
                    w_dwell_nxt   = '0;
                    w_first_nxt   = 1'b0;
                end else if (w_code == r_phase) begin
                    if (r_dwell != L_DWELL_MAX) begin
                        w_dwell_nxt = r_dwell + L_DWELL_ONE;
                        w_err_dwell = (r_dwell == L_DWELL_MAX - L_DWELL_ONE);
                    end
                end else if (w_code == next_phase(r_phase)) begin
                    w_err_dwell = !r_first &&
                                  (32'(r_dwell) < min_dwell(r_phase, MIN_GREEN, MIN_YELLOW));
                    if (r_phase == PH_FY) begin
                        w_cycle_cnt_nxt = r_cycle_cnt + 8'd1;
                    end
                    w_phase_nxt = w_code;
                    w_dwell_nxt = L_DWELL_ONE;
                    w_first_nxt = 1'b0;
                end else begin
                    // Out-of-order jump: relock on the new phase and treat it as partial
                    w_err_seq   = 1'b1;
                    w_phase_nxt = w_code;
                    w_dwell_nxt = L_DWELL_ONE;
                    w_first_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_UNSYNC;
                w_phase_nxt = PH_OFF;
                w_dwell_nxt = '0;
                w_first_nxt = 1'b0;
            end
        endcase
        // A new error outranks a simultaneous clear
        w_err_sticky_nxt = (r_err_sticky & ~err_clr) | w_err_pattern | w_err_seq | w_err_dwell;
    end

    // Register all tracked state and error pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_UNSYNC;
            r_phase       <= PH_OFF;
            r_dwell       <= '0;
            r_first       <= 1'b0;
            r_cycle_cnt   <= 8'd0;
            r_err_pattern <= 1'b0;
            r_err_seq     <= 1'b0;
            r_err_dwell   <= 1'b0;
            r_err_sticky  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_phase       <= w_phase_nxt;
            r_dwell       <= w_dwell_nxt;
            r_first       <= w_first_nxt;
            r_cycle_cnt   <= w_cycle_cnt_nxt;
            r_err_pattern <= w_err_pattern;
            r_err_seq     <= w_err_seq;
            r_err_dwell   <= w_err_dwell;
            r_err_sticky  <= w_err_sticky_nxt;
        end
    end

    assign phase       = r_phase;
    assign synced      = (r_state == ST_SYNCED);
    assign err_pattern = r_err_pattern;
    assign err_seq     = r_err_seq;
    assign err_dwell   = r_err_dwell;
    assign err_sticky  = r_err_sticky;
    assign cycle_cnt   = r_cycle_cnt;
    assign dwell       = r_dwell;

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker at the receiving end of the `traffic_light` lamp interface. It samples the eight lamp outputs every `clk`, decodes them into a phase, and tracks the highway/farm phase sequence. It flags illegal lamp patterns, out-of-order transitions and dwell-time violations, and counts completed light cycles. It sits beside `traffic_light` in system benches and on silicon debug taps, and never drives the controller.

## Interface
- `MIN_GREEN`, 2: minimum legal dwell, in cycles, of HGS/HGL/HGR/FG phases.
- `MIN_YELLOW`, 2: minimum legal dwell of HY/FY phases.
- `MAX_PHASE`, 64: dwell saturation value; reaching it is a stuck-phase error.
- `DW`, `$clog2(MAX_PHASE+1)`: dwell counter width (derived; 7 at default).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `HGS`, `HGL`, `HGR`, `HY`, `HR`, `FG`, `FY`, `FR` in 1 each: lamp signals from the controller, synchronous to `clk`.
- `err_clr` in 1: synchronous clear of `err_sticky`.
- `phase` out 3: tracked phase code.
- `synced` out 1: the monitor is locked to the sequence.
- `err_pattern` out 1: one-cycle pulse on an illegal lamp combination.
- `err_seq` out 1: one-cycle pulse on an illegal transition.
- `err_dwell` out 1: one-cycle pulse on a too-short or stuck phase.
- `err_sticky` out 1: OR of all error pulses, held until cleared.
- `cycle_cnt` out 8: number of completed FY→HGS wraps.
- `dwell` out DW: cycles spent in the current phase.

## Operation
Phase codes:
- OFF=0: all lamps dark.
- HGS=1: HGS+FR.
- HGL=2: HGL+FR.
- HGR=3: HGR+FR.
- HY=4: HY+FR.
- FG=5: HR+FG.
- FY=6: HR+FY.
- BAD=7: any other combination.

Legal cycle: HGS→HGL→HGR→HY→FG→FY→HGS. Holding the same phase is always legal.

States:
- UNSYNC (reset state).
  - OFF is accepted silently.
  - The first legal code 1–6 sets `synced`=1 and becomes `phase`.
  - Dwell is loaded with 1 and the first-phase flag is set; the first phase skips the minimum-dwell check because it may be partial.
  - BAD pulses `err_pattern` and the monitor stays UNSYNC.
- SYNCED, same code as `phase`:
  - `dwell` increments, saturating at MAX_PHASE.
  - The increment that reaches MAX_PHASE pulses `err_dwell` once.
- SYNCED, legal next code:
  - If the old phase was not the first phase and its dwell is below its minimum, pulse `err_dwell`.
  - Adopt the new phase, set dwell=1, clear the first-phase flag.
  - On FY→HGS, increment `cycle_cnt`, wrapping 255→0.
- SYNCED, a different code in 1–6 that is not the legal next code:
  - Pulse `err_seq`.
  - Adopt the new phase, set dwell=1, set the first-phase flag.
  - `cycle_cnt` is unchanged.
- SYNCED, OFF or BAD:
  - Pulse `err_pattern`.
  - Go to UNSYNC with `phase`=0, `dwell`=0, `synced`=0.

Error bookkeeping:
- `err_sticky` is set by any error pulse and cleared by `err_clr`.
- If `err_clr` and a new error occur in the same cycle, the error wins and `err_sticky` stays 1.
- More than one error pulse may assert in the same cycle.

## Timing
- Lamp inputs are decoded combinationally and evaluated at every rising `clk`.
- All outputs are registered and reflect the lamps sampled at the preceding edge, so latency is 1 cycle.
- Reset values: `phase`=0, `synced`=0, all `err_*`=0, `err_sticky`=0, `cycle_cnt`=0, `dwell`=0.
- Reset mid-operation forces these values immediately and asynchronously.
- After reset deasserts, resync happens on the first legal sample.

## Structure
- Package `tl_pkg` holds the phase-code enum (OFF…BAD), the next-phase function, and the min-dwell-per-phase function.
- Sub-module `tl_lamp_decode` is purely combinational: eight lamps in, 3-bit phase code out.
- The top module holds the sync FSM, dwell counter, cycle counter and error registers.

## Test plan
- Reset low, then a legal sequence with dwells HGS=5, HGL=3, HGR=3, HY=2, FG=4, FY=2, repeated 3 times → `synced`=1 one cycle after the first HGS sample, no error pulses, `cycle_cnt`=2 after the third entry into HGS.
- HY dwell of 1 in the middle of a synced sequence → `err_dwell` pulses for 1 cycle on the HY→FG edge, `err_sticky`=1, `cycle_cnt` unaffected.
- HGS and FG lit together (code BAD) while synced → `err_pattern` pulse, `synced`=0, `phase`=0; the next legal HGL causes resync with no dwell check on that first phase.
- HGS→HY skip → `err_seq` pulse, `phase`=4, `dwell`=1; a following FY→HGS wrap still increments `cycle_cnt`.
- HGS held for 70 cycles → a single `err_dwell` pulse when `dwell` reaches 64, and `dwell` stays at 64.
- `err_clr` asserted in the same cycle as an `err_seq` pulse → `err_sticky` stays 1; `err_clr` alone on a later cycle → `err_sticky`=0. Asynchronous reset asserted mid-cycle → all outputs zero immediately.
